// File: rtl/mem_arbiter.sv
// Request arbiter for the byte-serial memory engine: fixed priority store > load > fetch,
// a starvation override for fetch, and rollback cancellation of speculative reads.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        io_buffer_full,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_done,
  output logic [31:0] if_data,

  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_grant,
  output logic        ld_done,
  output logic [31:0] ld_data,

  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_grant,
  output logic        st_done,

  output logic        eng_valid,
  output logic        eng_write,
  output logic [31:0] eng_addr,
  output logic [31:0] eng_wdata,
  output logic [1:0]  eng_size,
  output logic        eng_signed,
  input  logic        eng_ack,
  input  logic        eng_done,
  input  logic [31:0] eng_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOAD,
    OWN_STORE
  } owner_t;

  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic [3:0]  r_starve;
  logic [3:0]  w_starve_nxt;

  logic        r_if_grant,   w_if_grant_nxt;
  logic        r_ld_grant,   w_ld_grant_nxt;
  logic        r_st_grant,   w_st_grant_nxt;
  logic        r_if_done,    w_if_done_nxt;
  logic        r_ld_done,    w_ld_done_nxt;
  logic        r_st_done,    w_st_done_nxt;
  logic [31:0] r_if_data,    w_if_data_nxt;
  logic [31:0] r_ld_data,    w_ld_data_nxt;

  logic        r_eng_valid,  w_eng_valid_nxt;
  logic        r_eng_write,  w_eng_write_nxt;
  logic [31:0] r_eng_addr,   w_eng_addr_nxt;
  logic [31:0] r_eng_wdata,  w_eng_wdata_nxt;
  logic [1:0]  r_eng_size,   w_eng_size_nxt;
  logic        r_eng_signed, w_eng_signed_nxt;

  logic        w_io_block;
  logic        w_starved;
  logic        w_arb_en;
  logic        w_gnt_st;
  logic        w_gnt_ld;
  logic        w_gnt_if;
  logic        w_spec_owner;
  logic        w_abort;
  logic        w_complete;

  // A store to the UART window stalls all arbitration so nothing overtakes it.
  assign w_io_block = st_req && (st_addr[17:16] == 2'b11) && io_buffer_full;
  assign w_starved  = ({1'b0, r_starve} >= LIMIT);
  assign w_arb_en   = (r_state == S_IDLE) && !rollback && !w_io_block;

  assign w_gnt_st = w_arb_en && st_req;
  assign w_gnt_if = w_arb_en && !st_req && if_req && (w_starved || !ld_req);
  assign w_gnt_ld = w_arb_en && !st_req && ld_req && !(if_req && w_starved);

  // Reads are speculative and die on rollback; committed stores always finish.
  assign w_spec_owner = (r_owner == OWN_LOAD) || (r_owner == OWN_FETCH);
  assign w_abort      = (r_state != S_IDLE) && rollback && w_spec_owner;
  assign w_complete   = !w_abort &&
                        (((r_state == S_WAIT) && eng_done) ||
                         ((r_state == S_ISSUE) && eng_ack && eng_done));

  always_comb begin
    w_starve_nxt = r_starve;
    if ((r_state == S_IDLE) && rollback) begin
      w_starve_nxt = 4'd0;
    end else if (!if_req || w_gnt_if) begin
      w_starve_nxt = 4'd0;
    end else if ((w_gnt_st || w_gnt_ld) && (r_starve != 4'hF)) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_if_grant_nxt   = 1'b0;
    w_ld_grant_nxt   = 1'b0;
    w_st_grant_nxt   = 1'b0;
    w_if_done_nxt    = 1'b0;
    w_ld_done_nxt    = 1'b0;
    w_st_done_nxt    = 1'b0;
    w_if_data_nxt    = r_if_data;
    w_ld_data_nxt    = r_ld_data;
    w_eng_valid_nxt  = r_eng_valid;
    w_eng_write_nxt  = r_eng_write;
    w_eng_addr_nxt   = r_eng_addr;
    w_eng_wdata_nxt  = r_eng_wdata;
    w_eng_size_nxt   = r_eng_size;
    w_eng_signed_nxt = r_eng_signed;

    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_st) begin
          w_st_grant_nxt   = 1'b1;
          w_owner_nxt      = OWN_STORE;
          w_state_nxt      = S_ISSUE;
          w_eng_valid_nxt  = 1'b1;
          w_eng_write_nxt  = 1'b1;
          w_eng_addr_nxt   = st_addr;
          w_eng_wdata_nxt  = st_data;
          w_eng_size_nxt   = st_size;
          w_eng_signed_nxt = 1'b0;
        end else if (w_gnt_if) begin
          w_if_grant_nxt   = 1'b1;
          w_owner_nxt      = OWN_FETCH;
          w_state_nxt      = S_ISSUE;
          w_eng_valid_nxt  = 1'b1;
          w_eng_write_nxt  = 1'b0;
          w_eng_addr_nxt   = if_addr;
          w_eng_wdata_nxt  = 32'd0;
          w_eng_size_nxt   = 2'd2;
          w_eng_signed_nxt = 1'b0;
        end else if (w_gnt_ld) begin
          w_ld_grant_nxt   = 1'b1;
          w_owner_nxt      = OWN_LOAD;
          w_state_nxt      = S_ISSUE;
          w_eng_valid_nxt  = 1'b1;
          w_eng_write_nxt  = 1'b0;
          w_eng_addr_nxt   = ld_addr;
          w_eng_wdata_nxt  = 32'd0;
          w_eng_size_nxt   = ld_size;
          w_eng_signed_nxt = ld_signed;
        end
      end

      S_ISSUE: begin
        if (w_abort) begin
          w_state_nxt     = S_IDLE;
          w_owner_nxt     = OWN_NONE;
          w_eng_valid_nxt = 1'b0;
        end else if (eng_ack) begin
          w_eng_valid_nxt = 1'b0;
          w_state_nxt     = eng_done ? S_IDLE : S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_owner_nxt = OWN_NONE;
        end else if (eng_done) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_owner_nxt     = OWN_NONE;
        w_eng_valid_nxt = 1'b0;
      end
    endcase

    if (w_complete) begin
      w_owner_nxt = OWN_NONE;
      unique case (r_owner)
        OWN_FETCH: begin
          w_if_done_nxt = 1'b1;
          w_if_data_nxt = eng_rdata;
        end
        OWN_LOAD: begin
          w_ld_done_nxt = 1'b1;
          w_ld_data_nxt = eng_rdata;
        end
        OWN_STORE: w_st_done_nxt = 1'b1;
        default:   w_owner_nxt   = OWN_NONE;
      endcase
    end
  end

  // rdy low freezes everything, including a pulse that is currently high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_starve     <= 4'd0;
      r_if_grant   <= 1'b0;
      r_ld_grant   <= 1'b0;
      r_st_grant   <= 1'b0;
      r_if_done    <= 1'b0;
      r_ld_done    <= 1'b0;
      r_st_done    <= 1'b0;
      r_if_data    <= 32'd0;
      r_ld_data    <= 32'd0;
      r_eng_valid  <= 1'b0;
      r_eng_write  <= 1'b0;
      r_eng_addr   <= 32'd0;
      r_eng_wdata  <= 32'd0;
      r_eng_size   <= 2'd0;
      r_eng_signed <= 1'b0;
    end else if (rdy) begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve     <= w_starve_nxt;
      r_if_grant   <= w_if_grant_nxt;
      r_ld_grant   <= w_ld_grant_nxt;
      r_st_grant   <= w_st_grant_nxt;
      r_if_done    <= w_if_done_nxt;
      r_ld_done    <= w_ld_done_nxt;
      r_st_done    <= w_st_done_nxt;
      r_if_data    <= w_if_data_nxt;
      r_ld_data    <= w_ld_data_nxt;
      r_eng_valid  <= w_eng_valid_nxt;
      r_eng_write  <= w_eng_write_nxt;
      r_eng_addr   <= w_eng_addr_nxt;
      r_eng_wdata  <= w_eng_wdata_nxt;
      r_eng_size   <= w_eng_size_nxt;
      r_eng_signed <= w_eng_signed_nxt;
    end
  end

  assign if_grant   = r_if_grant;
  assign ld_grant   = r_ld_grant;
  assign st_grant   = r_st_grant;
  assign if_done    = r_if_done;
  assign ld_done    = r_ld_done;
  assign st_done    = r_st_done;
  assign if_data    = r_if_data;
  assign ld_data    = r_ld_data;
  assign eng_valid  = r_eng_valid;
  assign eng_write  = r_eng_write;
  assign eng_addr   = r_eng_addr;
  assign eng_wdata  = r_eng_wdata;
  assign eng_size   = r_eng_size;
  assign eng_signed = r_eng_signed;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority order, IO blocking, rollback,
// starvation override and rdy freeze, with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        if_done;
  logic [31:0] if_data;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        ld_grant;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_grant;
  logic        st_done;
  logic        eng_valid;
  logic        eng_write;
  logic [31:0] eng_addr;
  logic [31:0] eng_wdata;
  logic [1:0]  eng_size;
  logic        eng_signed;
  logic        eng_ack;
  logic        eng_done;
  logic [31:0] eng_rdata;

  int passCount  = 0;
  int checkCount = 0;

  // Packed views: grants/dones as {st, ld, if}; command as {valid, write, size, signed}.
  logic [31:0] grantVec;
  logic [31:0] doneVec;
  logic [31:0] cmdVec;
  assign grantVec = {29'd0, st_grant, ld_grant, if_grant};
  assign doneVec  = {29'd0, st_done, ld_done, if_done};
  assign cmdVec   = {27'd0, eng_valid, eng_write, eng_size, eng_signed};

  mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_grant(ld_grant), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_grant(st_grant), .st_done(st_done),
    .eng_valid(eng_valid), .eng_write(eng_write), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_size(eng_size), .eng_signed(eng_signed), .eng_ack(eng_ack), .eng_done(eng_done),
    .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic done, input logic [31:0] rdata);
    eng_ack   = ack;
    eng_done  = done;
    eng_rdata = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ld_req = 1'b0; ld_addr = 32'd0; ld_size = 2'd0; ld_signed = 1'b0;
    st_req = 1'b1; st_addr = 32'h1234; st_data = 32'h5678; st_size = 2'd2;
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset holds everything at zero even with a request present
    tick();
    tick();
    checkOutput("reset_grants", grantVec, 32'h0);
    checkOutput("reset_dones", doneVec, 32'h0);
    checkOutput("reset_cmd", cmdVec, 32'h0);
    checkOutput("reset_eng_addr", eng_addr, 32'h0);
    checkOutput("reset_eng_wdata", eng_wdata, 32'h0);
    checkOutput("reset_if_data", if_data, 32'h0);
    checkOutput("reset_ld_data", ld_data, 32'h0);
    st_req = 1'b0;
    rst = 1'b0;
    tick();

    $display("[TB] simultaneous requests");
    st_req = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_size = 2'd2;
    ld_req = 1'b1; ld_addr = 32'h200; ld_size = 2'd1; ld_signed = 1'b1;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    checkOutput("simul_st_grant", grantVec, 32'h4);
    checkOutput("simul_st_cmd", cmdVec, 32'h1C);
    checkOutput("simul_st_addr", eng_addr, 32'h100);
    checkOutput("simul_st_wdata", eng_wdata, 32'hDEADBEEF);
    st_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("simul_ack_cmd", cmdVec, 32'h0C);
    checkOutput("simul_grant_pulse", grantVec, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("simul_wait_%0d", i), grantVec | doneVec, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("simul_st_done", doneVec, 32'h4);
    checkOutput("simul_done_no_grant", grantVec, 32'h0);
    tick();
    checkOutput("simul_ld_grant", grantVec, 32'h2);
    checkOutput("simul_ld_cmd", cmdVec, 32'h13);
    checkOutput("simul_ld_addr", eng_addr, 32'h200);
    ld_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 32'hFFFF8001);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("simul_ld_done", doneVec, 32'h2);
    checkOutput("simul_ld_data", ld_data, 32'hFFFF8001);
    tick();
    checkOutput("simul_if_grant", grantVec, 32'h1);
    checkOutput("simul_if_cmd", cmdVec, 32'h14);
    checkOutput("simul_if_addr", eng_addr, 32'h300);
    if_req = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h12345678);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("ackdone_if_done", doneVec, 32'h1);
    checkOutput("ackdone_if_data", if_data, 32'h12345678);
    checkOutput("ackdone_valid", cmdVec, 32'h04);
    tick();
    checkOutput("done_one_cycle", doneVec, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hBAD0BAD0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("stray_done", doneVec, 32'h0);
    checkOutput("stray_done_data", if_data, 32'h12345678);

    $display("[TB] IO-blocked store");
    st_req = 1'b1; st_addr = 32'h30000; st_data = 32'h41; st_size = 2'd0;
    io_buffer_full = 1'b1;
    ld_req = 1'b1; ld_addr = 32'h400; ld_size = 2'd2; ld_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("io_block_%0d", i), grantVec, 32'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    checkOutput("io_st_grant", grantVec, 32'h4);
    checkOutput("io_st_cmd", cmdVec, 32'h18);
    checkOutput("io_st_addr", eng_addr, 32'h30000);
    st_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("io_st_done", doneVec, 32'h4);

    $display("[TB] rollback on a load, then rdy freeze");
    tick();
    checkOutput("rb_ld_grant", grantVec, 32'h2);
    ld_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    rollback = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    tick();
    rollback = 1'b0;
    checkOutput("rb_ld_no_grant", grantVec, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h77777777);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("rb_ld_no_done", doneVec, 32'h0);
    checkOutput("rb_ld_data_held", ld_data, 32'hFFFF8001);
    checkOutput("rb_if_grant", grantVec, 32'h1);
    checkOutput("rb_if_addr", eng_addr, 32'h500);
    if_req = 1'b0;
    rdy = 1'b0; if_addr = 32'hFFFF0000; eng_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("freeze_grant_%0d", i), grantVec, 32'h1);
      checkOutput($sformatf("freeze_cmd_%0d", i), cmdVec, 32'h14);
      checkOutput($sformatf("freeze_addr_%0d", i), eng_addr, 32'h500);
    end
    rdy = 1'b1; eng_ack = 1'b0;
    tick();
    checkOutput("thaw_grant_clear", grantVec, 32'h0);
    checkOutput("thaw_cmd", cmdVec, 32'h14);
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hCAFEF00D);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("thaw_if_done", doneVec, 32'h1);
    checkOutput("thaw_if_data", if_data, 32'hCAFEF00D);

    $display("[TB] rollback on a store");
    st_req = 1'b1; st_addr = 32'h800; st_data = 32'h55AA; st_size = 2'd1;
    tick();
    checkOutput("rbst_grant", grantVec, 32'h4);
    checkOutput("rbst_wdata", eng_wdata, 32'h55AA);
    st_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    checkOutput("rbst_no_early_done", doneVec, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("rbst_st_done", doneVec, 32'h4);
    tick();
    checkOutput("rbst_done_pulse", doneVec, 32'h0);

    $display("[TB] starvation override");
    if_req = 1'b1; if_addr = 32'h900;
    ld_req = 1'b1; ld_addr = 32'hA00; ld_size = 2'd2; ld_signed = 1'b0;
    for (int round = 0; round < 2; round++) begin
      for (int n = 0; n < 8; n++) begin
        tick();
        checkOutput($sformatf("starve_r%0d_ld%0d", round, n), grantVec, 32'h2);
        applyStimulus(1'b1, 1'b1, 32'(n));
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0);
      end
      tick();
      checkOutput($sformatf("starve_r%0d_fetch", round), grantVec, 32'h1);
      checkOutput($sformatf("starve_r%0d_fetch_addr", round), eng_addr, 32'h900);
      applyStimulus(1'b1, 1'b1, 32'hF00D0000);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput($sformatf("starve_r%0d_fetch_done", round), doneVec, 32'h1);
    end
    if_req = 1'b0;
    ld_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
